// File: rtl/ro_puf_pkg.sv
// ro_puf_pkg: shared defaults and FSM state type for the RO-PUF datapath
package ro_puf_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_TERMINAL = 255;
  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;
endpackage

// File: rtl/ro_post_mux_counter.sv
// ro_post_mux_counter: enabled edge counter that saturates at TERMINAL and raises a sticky finished flag
module ro_post_mux_counter
  import ro_puf_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int TERMINAL = DEF_TERMINAL
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic [WIDTH-1:0] out,
  output logic             finished
);
  localparam logic [WIDTH-1:0] TERM = WIDTH'(TERMINAL);
  state_t state, state_n;
  logic [WIDTH-1:0] inc, out_n;
  logic step, fin_n;
  // state register, cleared asynchronously
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  // next state: an enabled edge outside DONE advances, landing in DONE when the count hits TERMINAL
  always_comb begin
    inc = out + WIDTH'(1);
    step = enable && state != DONE;
    state_n = step ? (inc == TERM ? DONE : COUNT) : state;
  end
  // next outputs: count follows the step, finished tracks entry into DONE
  always_comb begin
    out_n = step ? inc : out;
    fin_n = state_n == DONE;
  end
  // output registers keep both outputs flop-driven
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      out <= '0;
      finished <= 1'b0;
    end else begin
      out <= out_n;
      finished <= fin_n;
    end
endmodule

// File: tb/tb_ro_post_mux_counter.sv
// tb_ro_post_mux_counter: scoreboard bench checking counting, pause, saturation and async reset
module tb_ro_post_mux_counter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b1;
  logic [7:0] out;
  logic finished;
  logic [7:0] m_out = 8'd0;
  logic m_fin = 1'b0;
  logic [8:0] q[$];
  logic [8:0] exp_v;
  int checks = 0;
  int fails = 0;
  ro_post_mux_counter #(.WIDTH(8), .TERMINAL(255)) dut (
    .clk(clk), .reset(reset), .enable(enable), .out(out), .finished(finished)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed fin=%0b out=%0d expected fin=%0b out=%0d", tag, obs[8], obs[7:0], exp[8], exp[7:0]);
    end
  endtask
  task automatic model_edge();
    if (reset) begin
      m_out = 8'd0;
      m_fin = 1'b0;
    end else if (enable && !m_fin) begin
      m_out = m_out + 8'd1;
      if (m_out == 8'd255) m_fin = 1'b1;
    end
  endtask
  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      model_edge();
      q.push_back({m_fin, m_out});
      @(posedge clk);
      #1;
      exp_v = q.pop_front();
      chk(tag, {finished, out}, exp_v);
    end
  endtask
  task automatic async_reset(input string tag);
    reset = 1'b1;
    m_out = 8'd0;
    m_fin = 1'b0;
    #1;
    chk(tag, {finished, out}, 9'd0);
    reset = 1'b0;
  endtask
  initial begin
    #1;
    chk("reset_t0", {finished, out}, 9'd0);
    run(4, "reset_hold");
    reset = 1'b0;
    run(1, "first_edge");
    chk("out_is_1", {1'b0, out}, 9'd1);
    run(1, "second_edge");
    chk("out_is_2", {1'b0, out}, 9'd2);
    run(252, "full_run");
    chk("pre_terminal", {finished, out}, 9'd254);
    run(1, "terminal_edge");
    chk("terminal", {finished, out}, {1'b1, 8'd255});
    run(40, "saturate");
    enable = 1'b0;
    run(3, "done_ignores_enable");
    enable = 1'b1;
    async_reset("post_finish_reset");
    enable = 1'b0;
    run(3, "idle_disabled");
    enable = 1'b1;
    run(50, "to_fifty");
    chk("at_fifty", {finished, out}, 9'd50);
    #3;
    async_reset("mid_reset");
    run(1, "restart");
    chk("restart_from_1", {finished, out}, 9'd1);
    run(99, "to_hundred");
    enable = 1'b0;
    run(5, "pause");
    chk("pause_hold", {finished, out}, 9'd100);
    enable = 1'b1;
    run(1, "resume");
    chk("resume_101", {finished, out}, 9'd101);
    run(153, "second_run");
    chk("second_pre_terminal", {finished, out}, 9'd254);
    run(1, "second_terminal");
    chk("second_finished", {finished, out}, {1'b1, 8'd255});
    run(20, "second_saturate");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
